// File: rtl/vx_commit_buffer_pkg.sv
// Shared constants and types for the commit buffer: packet width, framing bit
// positions, performance counter width and the input framing state enum.
package vx_commit_buffer_pkg;

   localparam int COMMIT_DATAW  = 64;
   localparam int EOP_BIT       = 0;
   localparam int SOP_BIT       = 1;
   localparam int PERF_CTR_BITS = 32;

   typedef enum logic {
      CLOSED = 1'b0,
      OPEN   = 1'b1
   } frame_state_e;

endpackage

// File: rtl/vx_commit_buffer_mem.sv
// DEPTH x DATAW storage for the commit buffer: one synchronous write port and
// one combinational read port.
module vx_commit_buffer_mem #(
   parameter  int DATAW = 64,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [PW-1:0]    wr_addr,
   input  logic [DATAW-1:0] wr_data,
   input  logic [PW-1:0]    rd_addr,
   output logic [DATAW-1:0] rd_data
);

   logic [DATAW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vx_commit_buffer.sv
// Elastic result buffer between an execute unit and its commit port, with
// sop/eop framing check. Optional stall counters under COMMIT_BUF_PERF_EN.
//
// Handshake: a transfer happens on a cycle where valid and ready are both high;
// valid never waits on ready, and in_ready/out_* are registered (no in-to-out or
// out_ready-to-in_ready combinational path).
module vx_commit_buffer
   import vx_commit_buffer_pkg::*;
#(
   parameter  int DATAW = COMMIT_DATAW,
   parameter  int DEPTH = 4,
   parameter  int AFULL = 3,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [DATAW-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [DATAW-1:0] out_data,
   input  logic             out_ready,
   output logic [CW-1:0]    count,
   output logic [CW-1:0]    instr_count,
   output logic             almost_full,
   output logic             frame_err,
   output frame_state_e     frame_state
`ifdef COMMIT_BUF_PERF_EN
   ,
   output logic [PERF_CTR_BITS-1:0] perf_stall_in,
   output logic [PERF_CTR_BITS-1:0] perf_stall_out
`endif
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("vx_commit_buffer: DEPTH must be a power of two >= 2");
   end
   if (AFULL < 1 || AFULL > DEPTH) begin : g_bad_afull
      $error("vx_commit_buffer: AFULL must be in 1..DEPTH");
   end

   logic             push, pop;
   logic             head_load, head_take_mem, head_take_in, mem_wr, mem_empty;
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [DATAW-1:0] mem_rd_data;
   logic [CW-1:0]    count_next, instr_next;
   frame_state_e     frame_next;
   logic             err_set;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   // The memory only holds entries behind the head register, so it never
   // exceeds DEPTH-1 entries and pointer equality alone means empty.
   assign mem_empty     = (wr_ptr == rd_ptr);
   assign head_load     = !out_valid | out_ready;
   assign head_take_mem = head_load & !mem_empty;
   assign head_take_in  = head_load & mem_empty & push;
   assign mem_wr        = push & !head_take_in;

   assign count_next = count + CW'(push) - CW'(pop);
   assign instr_next = instr_count + CW'(push & in_data[EOP_BIT])
                                   - CW'(pop & out_data[EOP_BIT]);

   vx_commit_buffer_mem #(
      .DATAW (DATAW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (mem_wr),
      .wr_addr (wr_ptr),
      .wr_data (in_data),
      .rd_addr (rd_ptr),
      .rd_data (mem_rd_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         count       <= '0;
         instr_count <= '0;
         in_ready    <= 1'b1;
         almost_full <= 1'b0;
      end else begin
         if (mem_wr) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (head_take_mem) begin
            out_data  <= mem_rd_data;
            out_valid <= 1'b1;
            rd_ptr    <= rd_ptr + PW'(1);
         end else if (head_take_in) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
         end else if (head_load) begin
            out_valid <= 1'b0;
         end
         count       <= count_next;
         instr_count <= instr_next;
         in_ready    <= (count_next < CW'(DEPTH));
         almost_full <= (count_next >= CW'(AFULL));
      end
   end

   // Framing follows the accepted input stream; the next state always tracks
   // the pushed packet's eop, errors are flagged but the packet is still kept.
   always_comb begin
      frame_next = frame_state;
      err_set    = 1'b0;
      if (push) begin
         case (frame_state)
            CLOSED: begin
               err_set    = !in_data[SOP_BIT];
               frame_next = in_data[EOP_BIT] ? CLOSED : OPEN;
            end
            OPEN: begin
               err_set    = in_data[SOP_BIT];
               frame_next = in_data[EOP_BIT] ? CLOSED : OPEN;
            end
            default: begin
               frame_next = CLOSED;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_state <= CLOSED;
         frame_err   <= 1'b0;
      end else begin
         frame_state <= frame_next;
         frame_err   <= frame_err | err_set;
      end
   end

`ifdef COMMIT_BUF_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_stall_in  <= '0;
         perf_stall_out <= '0;
      end else begin
         if (in_valid & !in_ready) begin
            perf_stall_in <= perf_stall_in + PERF_CTR_BITS'(1);
         end
         if (out_valid & !out_ready) begin
            perf_stall_out <= perf_stall_out + PERF_CTR_BITS'(1);
         end
      end
   end
`endif

endmodule
